// File: rtl/mixer_pkg.sv
// Shared types and arithmetic for the multi-channel offset-binary mixer.
// Build option: define MIXER_SAT_EN to clamp each combine result to [0, F-1];
// leave it undefined to keep the low W bits of each result (wrap).
package mixer_pkg;

    // Sequencer states: wait for a frame, fold voices one by one, present the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_OUT  = 2'd2
    } mix_state_t;

    // Mid-scale (silence) code M = 2^(w-1)
    function automatic longint mix_mid(input int unsigned w);
        return longint'(1) << (w - 1);
    endfunction

    // Full-scale span F = 2^w
    function automatic longint mix_full(input int unsigned w);
        return longint'(1) << w;
    endfunction

    // Signed width needed by the combine intermediate
    function automatic int unsigned mix_iw(input int unsigned w);
        return w + 3;
    endfunction

    // f(a,b) given p = (a*b) >> (w-1); 64-bit signed math contains the w+3 bit intermediate
    function automatic longint mix_combine(input int unsigned w, input longint a,
                                           input longint b, input longint p);
        longint mid;
        longint full;
        longint z;
        mid  = mix_mid(w);
        full = mix_full(w);
        if ((a < mid) && (b < mid)) begin
            z = p;
        end else begin
            z = 2 * a + 2 * b - p - full;
        end
`ifdef MIXER_SAT_EN
        if (z < 0) begin
            z = 0;
        end else if (z > full - 1) begin
            z = full - 1;
        end
`else
        z = z & (full - 1);
`endif
        return z;
    endfunction

endpackage

// File: rtl/mix_mult_pipe.sv
// Unsigned WxW -> 2W multiplier with MULT_LAT register stages.
// The datapath carries no reset; the sequencer only samples o_p once the
// operands have been stable for MULT_LAT cycles, so stale contents never matter.
module mix_mult_pipe #(
    parameter int unsigned W        = 18,
    parameter int unsigned MULT_LAT = 3
) (
    input  logic           clk,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    logic [2*W-1:0] r_pipe [MULT_LAT];

    // Multiply into the first stage, then shift down the remaining stages
    always_ff @(posedge clk) begin
        r_pipe[0] <= (2*W)'(i_a) * (2*W)'(i_b);
        for (int i = 1; i < int'(MULT_LAT); i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_p = r_pipe[MULT_LAT-1];

endmodule

// File: rtl/multi_channel_mixer.sv
// N-voice offset-binary mixer: folds CHANNELS samples through f(acc,x) using one
// shared pipelined multiplier. Result range handling follows MIXER_SAT_EN
// (clamp when defined, wrap otherwise).
module multi_channel_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned W        = 18,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MULT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CHANNELS*W-1:0] s_data,
    input  logic [CHANNELS-1:0]   chan_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [W-1:0]          m_data,
    output logic                  busy
);

    localparam int unsigned KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned LW = $clog2(MULT_LAT + 1);
    localparam logic [W-1:0]  MID      = W'(mix_mid(W));
    localparam logic [KW-1:0] K_LAST   = KW'(CHANNELS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(MULT_LAT);

    mix_state_t            r_state;
    logic [KW-1:0]         r_k;
    logic [LW-1:0]         r_lat;
    logic [W-1:0]          r_acc;
    logic [CHANNELS*W-1:0] r_data;
    logic [CHANNELS-1:0]   r_en;
    logic                  r_s_ready;
    logic                  r_m_valid;
    logic [W-1:0]          r_m_data;
    logic                  r_busy;

    logic [W-1:0]          w_x;
    logic [2*W-1:0]        w_prod;
    logic [W:0]            w_p;
    logic [W-1:0]          w_z;

    // Current voice operand; a disabled voice becomes silence, the identity of f
    assign w_x = r_en[r_k] ? r_data[r_k*W +: W] : MID;

    mix_mult_pipe #(
        .W        (W),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk (clk),
        .i_a (r_acc),
        .i_b (w_x),
        .o_p (w_prod)
    );

    // Scaled product and next accumulator value
    assign w_p = (W+1)'(w_prod >> (W - 1));
    assign w_z = W'(mix_combine(W, longint'(r_acc), longint'(w_x), longint'(w_p)));

    // Sequencer: accept a frame, one step of MULT_LAT+1 cycles per voice, then publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_lat     <= '0;
            r_acc     <= MID;
            r_data    <= '0;
            r_en      <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= MID;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid && r_s_ready) begin
                        r_data    <= s_data;
                        r_en      <= chan_en;
                        r_acc     <= MID;
                        r_k       <= '0;
                        r_lat     <= '0;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (r_lat == LAT_LAST) begin
                        r_acc <= w_z;
                        r_lat <= '0;
                        if (r_k == K_LAST) begin
                            r_state <= ST_OUT;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                ST_OUT: begin
                    // First OUT cycle loads the output register; then hold until taken
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_acc;
                    end else if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign busy    = r_busy;

endmodule
